// File: rtl/delay_scheduler.sv
// delay_scheduler
// Counts out a programmable delay in units of PRESCALE clock cycles and then
// emits a single-cycle expire pulse together with the latched resume address.
//
// Ports
//   clk          system clock, all state changes on its rising edge
//   rst          synchronous active-high reset
//   delay        request strobe, sampled every rising edge
//   delay_data   request payload: [23:8] tick count, [7:0] resume address
//   cancel       abort any pending delay (wins over delay)
//   indelay_data {remaining ticks, address} while counting, otherwise 0
//   busy         high while a delay is counting
//   expire       one-cycle pulse when a delay completes
//   jump_addr    resume address, valid whenever expire is high
module delay_scheduler #(
  parameter int PRESCALE = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        delay,
  input  logic [23:0] delay_data,
  input  logic        cancel,
  output logic [23:0] indelay_data,
  output logic        busy,
  output logic        expire,
  output logic [7:0]  jump_addr
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    EXPIRE
  } state_t;

  // Last prescaler value of a tick; the tick boundary is where cnt steps.
  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  state_t      state_reg;
  logic [15:0] cnt_reg;
  logic [7:0]  addr_reg;
  logic [15:0] pre_reg;

  logic [23:0] indelay_data_reg;
  logic        busy_reg;
  logic        expire_reg;
  logic [7:0]  jump_addr_reg;

  logic [15:0] req_ticks;
  logic [7:0]  req_addr;

  assign req_ticks = delay_data[23:8];
  assign req_addr  = delay_data[7:0];

  assign indelay_data = indelay_data_reg;
  assign busy         = busy_reg;
  assign expire       = expire_reg;
  assign jump_addr    = jump_addr_reg;

  // Outputs are registered alongside the state: every branch below sets them
  // to the values that belong to the state being entered, so they line up
  // with state_reg in the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      addr_reg         <= '0;
      pre_reg          <= '0;
      indelay_data_reg <= '0;
      busy_reg         <= 1'b0;
      expire_reg       <= 1'b0;
      jump_addr_reg    <= '0;
    end else if (cancel) begin
      // Abort without an expire pulse; jump_addr keeps its last value.
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      pre_reg          <= '0;
      indelay_data_reg <= '0;
      busy_reg         <= 1'b0;
      expire_reg       <= 1'b0;
    end else begin
      indelay_data_reg <= '0;
      busy_reg         <= 1'b0;
      expire_reg       <= 1'b0;

      if (delay) begin
        // A new request is taken in every state: from IDLE it starts, in
        // COUNT it re-arms (old delay silently dropped), and in EXPIRE it
        // follows the pulse that is already on the output.
        addr_reg <= req_addr;
        pre_reg  <= '0;
        if (req_ticks != 16'd0) begin
          state_reg        <= COUNT;
          cnt_reg          <= req_ticks;
          indelay_data_reg <= delay_data;
          busy_reg         <= 1'b1;
        end else begin
          state_reg     <= EXPIRE;
          cnt_reg       <= '0;
          expire_reg    <= 1'b1;
          jump_addr_reg <= req_addr;
        end
      end else begin
        case (state_reg)
          COUNT: begin
            if (pre_reg == PRE_MAX) begin
              pre_reg <= '0;
              // cnt is always >= 1 in COUNT, so the last tick ends here
              // instead of decrementing below one.
              if (cnt_reg == 16'd1) begin
                state_reg     <= EXPIRE;
                cnt_reg       <= '0;
                expire_reg    <= 1'b1;
                jump_addr_reg <= addr_reg;
              end else begin
                cnt_reg          <= cnt_reg - 16'd1;
                indelay_data_reg <= {cnt_reg - 16'd1, addr_reg};
                busy_reg         <= 1'b1;
              end
            end else begin
              pre_reg          <= pre_reg + 16'd1;
              indelay_data_reg <= {cnt_reg, addr_reg};
              busy_reg         <= 1'b1;
            end
          end
          EXPIRE: begin
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
